// File: rtl/issue_scheduler_pkg.sv
// Shared opcode constants, FSM state type and opcode-class helpers for the issue scheduler.
package issue_scheduler_pkg;

    localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
    localparam logic [6:0] OPCODE_OP       = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

    typedef enum logic {
        StRun   = 1'b0,
        StDrain = 1'b1
    } sched_state_e;

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == OPCODE_LUI || op == OPCODE_AUIPC || op == OPCODE_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OPCODE_OP || op == OPCODE_STORE || op == OPCODE_BRANCH);
    endfunction

    function automatic logic is_fence_op(input logic [6:0] op);
        return (op == OPCODE_MISC_MEM || op == OPCODE_SYSTEM);
    endfunction

endpackage

// File: rtl/issue_scheduler_reg_scoreboard.sv
// Pending-writeback bit vector with set, writeback-clear and kill-clear ports.
// Source reads and the effective-empty flag see the writeback clear in the same cycle.
module reg_scoreboard #(
    parameter int unsigned NREG = 32,
    localparam int unsigned IDX_W = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic             kill_en,
    input  logic [IDX_W-1:0] kill_idx,
    input  logic [IDX_W-1:0] rd_idx_a,
    input  logic [IDX_W-1:0] rd_idx_b,
    output logic             pend_a,
    output logic             pend_b,
    output logic             bit_clr,
    output logic             bit_kill,
    output logic             empty,
    output logic             empty_eff
);
    logic [NREG-1:0] sb_q, sb_d, sb_eff;
    logic [NREG-1:0] set_mask, clr_mask, kill_mask;

    always_comb begin
        set_mask  = '0;
        clr_mask  = '0;
        kill_mask = '0;
        if (set_en)  set_mask[set_idx]   = 1'b1;
        if (clr_en)  clr_mask[clr_idx]   = 1'b1;
        if (kill_en) kill_mask[kill_idx] = 1'b1;
        sb_eff = sb_q & ~clr_mask;
        // A set ORed in last wins over a clear of the same register.
        sb_d    = (sb_eff & ~kill_mask) | set_mask;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) sb_q <= '0;
        else        sb_q <= sb_d;
    end

    assign pend_a    = sb_eff[rd_idx_a];
    assign pend_b    = sb_eff[rd_idx_b];
    assign bit_clr   = sb_q[clr_idx];
    assign bit_kill  = sb_q[kill_idx];
    assign empty     = (sb_q == '0);
    assign empty_eff = (sb_eff == '0);

endmodule

// File: rtl/issue_scheduler.sv
// Decode-to-execute issue slot with RAW scoreboard, in-flight writeback limit,
// fence drain FSM and flush handling.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int unsigned NREG         = 32,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic        in_is_writeback,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  out_opcode,
    output logic [4:0]  out_rs,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [31:0] out_pc,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    output logic        busy
);
    sched_state_e     state_q, state_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             out_wb_q;

    logic pend_a, pend_b, bit_clr, bit_kill, sb_empty, sb_empty_eff;
    logic sets_rd, is_fence, hazard, slot_free, full, fence_block, accept;
    logic drop, wb_hit, kill_hit;
    logic [CNT_W+1:0] cnt_sum, cnt_dec, cnt_net;
    logic             cnt_under, cnt_over;

    // A slot dropped by flush retracts its own pending bit.
    assign drop = flush && out_valid && !out_ready;

    reg_scoreboard #(.NREG(NREG)) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (accept && sets_rd),
        .set_idx   (in_rd),
        .clr_en    (wb_valid),
        .clr_idx   (wb_rd),
        .kill_en   (drop && out_wb_q),
        .kill_idx  (out_rd),
        .rd_idx_a  (in_rs),
        .rd_idx_b  (in_rs2),
        .pend_a    (pend_a),
        .pend_b    (pend_b),
        .bit_clr   (bit_clr),
        .bit_kill  (bit_kill),
        .empty     (sb_empty),
        .empty_eff (sb_empty_eff)
    );

    always_comb begin
        sets_rd     = in_is_writeback && (in_rd != 5'd0);
        is_fence    = is_fence_op(in_opcode);
        hazard      = (uses_rs1(in_opcode) && pend_a) || (uses_rs2(in_opcode) && pend_b);
        slot_free   = !out_valid || out_ready;
        full        = (inflight_q >= CNT_W'(MAX_INFLIGHT));
        fence_block = is_fence && (!sb_empty_eff || out_valid);
        in_ready    = rst_n && (state_q == StRun) && !flush && slot_free && !hazard &&
                      !(sets_rd && full) && !fence_block;
        accept      = in_valid && in_ready;
        wb_hit      = wb_valid && bit_clr;
        // A writeback to the same register already accounts for the decrement.
        kill_hit    = drop && out_wb_q && bit_kill && !(wb_valid && (wb_rd == out_rd));
    end

    always_comb begin
        cnt_sum   = {2'b00, inflight_q} + {{(CNT_W+1){1'b0}}, accept && sets_rd};
        cnt_dec   = {{(CNT_W+1){1'b0}}, wb_hit} + {{(CNT_W+1){1'b0}}, kill_hit};
        cnt_net   = cnt_sum - cnt_dec;
        cnt_under = (cnt_sum < cnt_dec);
        cnt_over  = !cnt_under && (cnt_net > (CNT_W+2)'(MAX_INFLIGHT));
        if (cnt_under)     inflight_d = '0;
        else if (cnt_over) inflight_d = CNT_W'(MAX_INFLIGHT);
        else               inflight_d = cnt_net[CNT_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (in_valid && fence_block) state_d = StDrain;
            StDrain: if (sb_empty_eff && !out_valid) state_d = StRun;
            default: state_d = StRun;
        endcase
        if (flush) state_d = StRun;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StRun;
            inflight_q <= '0;
            out_valid  <= 1'b0;
            out_wb_q   <= 1'b0;
            out_opcode <= '0;
            out_rs     <= '0;
            out_rs2    <= '0;
            out_rd     <= '0;
            out_pc     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid  <= 1'b1;
                out_wb_q   <= sets_rd;
                out_opcode <= in_opcode;
                out_rs     <= in_rs;
                out_rs2    <= in_rs2;
                out_rd     <= in_rd;
                out_pc     <= in_pc;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = !sb_empty || out_valid;

    inflight_bounds: assert property (@(posedge clk) disable iff (!rst_n)
        !(cnt_under || cnt_over));

endmodule

// File: tb/tb_issue_scheduler.sv
// Scenario bench for issue_scheduler: issued instructions are checked in order against
// a queue of expected issues; handshake and status outputs are checked inline per scenario.
module tb_issue_scheduler;
    import issue_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_is_writeback;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rs, in_rs2, in_rd;
    logic [31:0] in_pc;
    logic        out_valid, out_ready;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rs, out_rs2, out_rd;
    logic [31:0] out_pc;
    logic        wb_valid, flush, busy;
    logic [4:0]  wb_rd;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [31:0] pc;
    } exp_t;
    exp_t exp_q[$];

    issue_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rs(in_rs), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_is_writeback(in_is_writeback), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_rs(out_rs), .out_rs2(out_rs2), .out_rd(out_rd), .out_pc(out_pc),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    // Issue monitor: handshake values are stable around the falling edge.
    always @(negedge clk) begin : issue_mon
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL issue_order: got op=%h rd=%0d pc=%h, required no issue",
                         out_opcode, out_rd, out_pc);
            end else begin
                e = exp_q.pop_front();
                if ({out_opcode, out_rd, out_pc} !== e) begin
                    n_fail++;
                    $display("FAIL issue_order: got op=%h rd=%0d pc=%h, required op=%h rd=%0d pc=%h",
                             out_opcode, out_rd, out_pc, e.op, e.rd, e.pc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [6:0] op, input logic [4:0] rs, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic wb, input logic [31:0] pc);
        in_valid = 1'b1; in_opcode = op; in_rs = rs; in_rs2 = rs2;
        in_rd = rd; in_is_writeback = wb; in_pc = pc;
        #1;
    endtask

    task automatic push_exp(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] pc);
        exp_q.push_back({op, rd, pc});
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd);
        wb_valid = v; wb_rd = rd;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_rs = '0; in_rs2 = '0; in_rd = '0;
        in_is_writeback = 1'b0; in_pc = '0; out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0;
        flush = 1'b0;
        step(); step();
        n_checks++;
        if ({in_ready, busy, out_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got ready/busy/valid=%b, required 000",
                     {in_ready, busy, out_valid});
        end
        n_checks++;
        if ({out_opcode, out_rs, out_rs2, out_rd, out_pc} !== 54'd0) begin
            n_fail++;
            $display("FAIL reset_fields: got pc=%h rd=%0d, required 0", out_pc, out_rd);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_raw_hazard();
        set_in(OPCODE_OP, 5'd1, 5'd2, 5'd5, 1'b1, 32'h100);
        push_exp(OPCODE_OP, 5'd5, 32'h100);
        step();
        set_in(OPCODE_OP, 5'd5, 5'd1, 5'd6, 1'b1, 32'h104);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL raw_stall[%0d]: got in_ready=%b, required 0", i, in_ready);
            end
            if (i == 0) step();
        end
        set_wb(1'b1, 5'd5);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_wb_bypass: got in_ready=%b, required 1", in_ready);
        end
        push_exp(OPCODE_OP, 5'd6, 32'h104);
        step();
        in_valid = 1'b0;
        set_wb(1'b1, 5'd6);
        step();
        set_wb(1'b0, 5'd0);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_idle_busy: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_x0_and_lui();
        set_in(OPCODE_LUI, 5'd0, 5'd0, 5'd7, 1'b1, 32'h200);
        push_exp(OPCODE_LUI, 5'd7, 32'h200);
        step();
        // LUI carries x7 in its rs field but does not read it.
        set_in(OPCODE_LUI, 5'd7, 5'd7, 5'd8, 1'b1, 32'h204);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lui_no_rs: got in_ready=%b, required 1", in_ready);
        end
        push_exp(OPCODE_LUI, 5'd8, 32'h204);
        step();
        set_in(OPCODE_OP_IMM, 5'd0, 5'd0, 5'd0, 1'b1, 32'h208);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_no_stall: got in_ready=%b, required 1", in_ready);
        end
        push_exp(OPCODE_OP_IMM, 5'd0, 32'h208);
        step();
        in_valid = 1'b0;
        set_wb(1'b1, 5'd7);
        step();
        set_wb(1'b1, 5'd8);
        step();
        set_wb(1'b0, 5'd0);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_not_pending: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_inflight_limit();
        for (int i = 1; i <= 4; i++) begin
            set_in(OPCODE_OP_IMM, 5'd0, 5'd0, 5'(i), 1'b1, 32'h300 + 32'(i * 4));
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL limit_fill[%0d]: got in_ready=%b, required 1", i, in_ready);
            end
            push_exp(OPCODE_OP_IMM, 5'(i), 32'h300 + 32'(i * 4));
            step();
        end
        set_in(OPCODE_OP_IMM, 5'd0, 5'd0, 5'd5, 1'b1, 32'h314);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL limit_block: got in_ready=%b, required 0", in_ready);
        end
        step();
        set_wb(1'b1, 5'd1);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL limit_wb_cycle: got in_ready=%b, required 0", in_ready);
        end
        step();
        set_wb(1'b0, 5'd0);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL limit_after_wb: got in_ready=%b, required 1", in_ready);
        end
        push_exp(OPCODE_OP_IMM, 5'd5, 32'h314);
        step();
        in_valid = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            set_wb(1'b1, 5'(i));
            step();
        end
        set_wb(1'b0, 5'd0);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL limit_cleanup_busy: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_fence_drain();
        set_in(OPCODE_OP_IMM, 5'd0, 5'd0, 5'd3, 1'b1, 32'h400);
        push_exp(OPCODE_OP_IMM, 5'd3, 32'h400);
        step();
        set_in(OPCODE_MISC_MEM, 5'd0, 5'd0, 5'd0, 1'b0, 32'h404);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fence_blocked: got in_ready=%b, required 0", in_ready);
        end
        step();
        // Pipeline would be empty with this writeback; only the drain state holds it off.
        set_wb(1'b1, 5'd3);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fence_in_drain: got in_ready=%b, required 0", in_ready);
        end
        step();
        set_wb(1'b0, 5'd0);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fence_accept: got in_ready=%b, required 1", in_ready);
        end
        push_exp(OPCODE_MISC_MEM, 5'd0, 32'h404);
        step();
        in_valid = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fence_idle_busy: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_in(OPCODE_OP, 5'd0, 5'd0, 5'd9, 1'b1, 32'h500);
        step();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, busy} !== 2'b11 || out_pc !== 32'h500) begin
            n_fail++;
            $display("FAIL flush_held: got valid/busy=%b pc=%h, required 11 pc=00000500",
                     {out_valid, busy}, out_pc);
        end
        flush = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready: got in_ready=%b, required 0", in_ready);
        end
        step();
        flush = 1'b0;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_dropped: got valid/busy=%b, required 00", {out_valid, busy});
        end
        // A full complement of four writes fits only if the dropped one was uncounted.
        for (int i = 0; i < 4; i++) begin
            set_in(OPCODE_OP_IMM, 5'd0, 5'd0, 5'(10 + i), 1'b1, 32'h510 + 32'(i * 4));
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL flush_inflight[%0d]: got in_ready=%b, required 1", i, in_ready);
            end
            push_exp(OPCODE_OP_IMM, 5'(10 + i), 32'h510 + 32'(i * 4));
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_wb(1'b1, 5'(10 + i));
            step();
        end
        set_wb(1'b0, 5'd0);
    endtask

    task automatic test_set_clear_and_reset();
        set_in(OPCODE_OP_IMM, 5'd0, 5'd0, 5'd4, 1'b1, 32'h600);
        push_exp(OPCODE_OP_IMM, 5'd4, 32'h600);
        step();
        set_in(OPCODE_OP_IMM, 5'd0, 5'd0, 5'd4, 1'b1, 32'h604);
        set_wb(1'b1, 5'd4);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL same_reg_ready: got in_ready=%b, required 1", in_ready);
        end
        push_exp(OPCODE_OP_IMM, 5'd4, 32'h604);
        step();
        in_valid = 1'b0;
        set_wb(1'b0, 5'd0);
        step();
        n_checks++;
        if ({out_valid, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL same_reg_pending: got valid/busy=%b, required 01", {out_valid, busy});
        end
        // One write in flight: three more fit, the fourth blocks.
        for (int i = 0; i < 3; i++) begin
            set_in(OPCODE_OP_IMM, 5'd0, 5'd0, 5'(20 + i), 1'b1, 32'h610 + 32'(i * 4));
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL same_reg_count[%0d]: got in_ready=%b, required 1", i, in_ready);
            end
            push_exp(OPCODE_OP_IMM, 5'(20 + i), 32'h610 + 32'(i * 4));
            step();
        end
        set_in(OPCODE_OP_IMM, 5'd0, 5'd0, 5'd23, 1'b1, 32'h61c);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL same_reg_full: got in_ready=%b, required 0", in_ready);
        end
        step();
        rst_n = 1'b0;
        step();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, busy, out_valid} !== 3'b000 || out_pc !== 32'd0 || out_rd !== 5'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got ready/busy/valid=%b pc=%h rd=%0d, required 000 0 0",
                     {in_ready, busy, out_valid}, out_pc, out_rd);
        end
        rst_n = 1'b1;
        step();
        set_in(OPCODE_OP_IMM, 5'd4, 5'd0, 5'd24, 1'b1, 32'h700);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_forgotten: got in_ready=%b, required 1", in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_raw_hazard();
        test_x0_and_lui();
        test_inflight_limit();
        test_fence_drain();
        test_flush();
        test_set_clear_and_reset();
        step(); step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL issue_drain: got %0d expected issues outstanding, required 0",
                     exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
